// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: mhpmcounter3.. bank with event selectors and inhibit.
// Define HPM_OVERFLOW_IRQ_EN for sticky OF/IE bits and hpm_irq.
module hpm_counter_bank #(
  parameter int NUM_COUNTERS = 4,
  parameter int NUM_EVENTS   = 16,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  input  logic [2:0]            csr_op,
  output logic [31:0]           csr_rdata,
  output logic                  csr_valid,
  input  logic [NUM_EVENTS-1:0] events_i,
  output logic                  hpm_irq
);

`ifdef HPM_OVERFLOW_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam logic [7:0] NEV = 8'(NUM_EVENTS);

  logic [NUM_EVENTS-1:0]   ev_q, ev_d;
  logic [NUM_COUNTERS-1:0] inh_q, inh_d;
  logic [NUM_COUNTERS-1:0] of_q, of_d;
  logic [NUM_COUNTERS-1:0] ie_q, ie_d;
  logic [7:0]              sel_q [NUM_COUNTERS];
  logic [7:0]              sel_d [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0]    cnt_d [NUM_COUNTERS];
  logic                    irq_q, irq_d;

  logic [6:0]   blk;
  logic [4:0]   idx;
  logic         inh_hit, evt_hit, lo_hit, hi_hit, shadow, we;
  logic [31:0]  wv;
  logic [255:0] ev_ext;
  logic [7:0]   sel_m1;
  logic         inc, cnt_wr;
  logic         unused_op;

  assign unused_op = csr_op[2];

  always_comb begin
    blk       = csr_addr[11:5];
    idx       = csr_addr[4:0];
    inh_hit   = (blk == 7'h19) && (idx == 5'd0);
    evt_hit   = (blk == 7'h19) && (idx >= 5'd3);
    lo_hit    = ((blk == 7'h58) || (blk == 7'h60)) && (idx >= 5'd3);
    hi_hit    = ((blk == 7'h5C) || (blk == 7'h64)) && (idx >= 5'd3);
    shadow    = (blk == 7'h60) || (blk == 7'h64);
    csr_valid = inh_hit | evt_hit | lo_hit | hi_hit;
    csr_rdata = '0;
    if (inh_hit) csr_rdata = 32'(inh_q) << 3;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (idx == 5'(k + 3)) begin
        if (evt_hit)
          csr_rdata = {of_q[k], ie_q[k], 22'd0, sel_q[k]};
        if (lo_hit) csr_rdata = cnt_q[k][31:0];
        if (hi_hit) csr_rdata = 32'(cnt_q[k][CNT_WIDTH-1:32]);
      end
    end
    case (csr_op[1:0])
      2'b10:   wv = csr_rdata | csr_wdata;
      2'b11:   wv = csr_rdata & ~csr_wdata;
      default: wv = csr_wdata;
    endcase
    we = (csr_op[1:0] != 2'b00) && csr_valid && !shadow;
  end

  always_comb begin
    ev_d   = events_i;
    inh_d  = inh_q;
    of_d   = of_q;
    ie_d   = ie_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    ev_ext = 256'(ev_q);
    sel_m1 = '0;
    inc    = 1'b0;
    cnt_wr = 1'b0;
    if (we && inh_hit) inh_d = wv[NUM_COUNTERS+2:3];
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      sel_m1 = sel_q[k] - 8'd1;
      inc    = (sel_q[k] != 8'd0) && (sel_q[k] <= NEV) &&
               ev_ext[sel_m1] && !inh_q[k];
      cnt_wr = we && (idx == 5'(k + 3)) && (lo_hit || hi_hit);
      if (we && (idx == 5'(k + 3))) begin
        if (evt_hit) begin
          sel_d[k] = wv[7:0];
          if (OVF_EN) begin
            of_d[k] = wv[31];
            ie_d[k] = wv[30];
          end
        end
        if (lo_hit) cnt_d[k][31:0] = wv;
        if (hi_hit)
          cnt_d[k][CNT_WIDTH-1:32] = wv[CNT_WIDTH-33:0];
      end
      // a CSR write to the counter swallows a same-edge increment
      if (inc && !cnt_wr) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        if (OVF_EN && (&cnt_q[k])) of_d[k] = 1'b1;
      end
    end
    irq_d = OVF_EN && (|(of_q & ie_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_q  <= '0;
      inh_q <= '0;
      of_q  <= '0;
      ie_q  <= '0;
      sel_q <= '{default: '0};
      cnt_q <= '{default: '0};
      irq_q <= 1'b0;
    end else begin
      ev_q  <= ev_d;
      inh_q <= inh_d;
      of_q  <= of_d;
      ie_q  <= ie_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign hpm_irq = OVF_EN & irq_q;

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised bank of RISC-V hardware performance-monitor counters, mhpmcounter3..mhpmcounter(2+NUM_COUNTERS), with per-counter event selectors, a counter-inhibit register and optional overflow interrupts. It sits beside the machine CSR unit on the same CSR read/write bus and decodes only the HPM address ranges. It extends the fixed cycle/instret counters with configurable width, counter count and event routing.

## Interface
- NUM_COUNTERS, 4, implemented counters (1..29); counter k maps to index 3+k.
- NUM_EVENTS, 16, width of event input (1..255).
- CNT_WIDTH, 64, counter width in bits (33..64).
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  write operand.
- csr_op  in  3  000 none; [1:0]=01 write, 10 set bits, 11 clear bits.
- csr_rdata  out  32  combinational read data.
- csr_valid  out  1  address is in an HPM range below.
- events_i  in  NUM_EVENTS  one-cycle event pulses; bit j is event j+1.
- hpm_irq  out  1  overflow interrupt request (level).

## Operation
- Address map, idx = 3..31:
  - mcountinhibit 0x320.
  - mhpmevent 0x320+idx.
  - mhpmcounter 0xB00+idx.
  - mhpmcounterh 0xB80+idx.
  - read-only shadows 0xC00+idx and 0xC80+idx.
- csr_valid=1 across all of these; 0 elsewhere (csr_rdata=0).
- Unimplemented idx (≥3+NUM_COUNTERS): reads 0, writes ignored.
- Writes to shadows are ignored. Reads behave as read data from the matching mhpmcounter/mhpmcounterh.
- Write value = csr_wdata (01), rdata|wdata (10), rdata&~wdata (11).
- mcountinhibit: bits [2+NUM_COUNTERS:3] writable. All other bits read 0.
- mhpmevent[7:0] = selector.
  - 0 = never count.
  - s in 1..NUM_EVENTS counts events_i[s-1].
  - s > NUM_EVENTS never counts.
  - Bits [29:8] read 0.
- Counter: CNT_WIDTH bits.
  - Low word is bits [31:0].
  - mhpmcounterh returns bits [CNT_WIDTH-1:32], zero-extended. Writes to bits above CNT_WIDTH are dropped.
  - Carry from low into high half is internal to one counter.
- Increment by 1 when the registered event is selected and the inhibit bit is 0.
- Wrap: all-ones + 1 → 0.

## Timing
- Reset values: all counters 0, selectors 0, mcountinhibit 0, OF bits 0, event register 0, hpm_irq 0.
- rst mid-operation clears all of the above on that edge. No increment or write lands on that edge.
- events_i is registered once. A pulse in cycle N increments at the end of cycle N+1 and is readable in cycle N+2.
- The selector and inhibit used for an increment are the values held during cycle N+1.
  - A write in cycle N+1 does not affect that increment.
  - A write in cycle N does affect it.
- A CSR write in cycle N updates state at the end of cycle N. A read in N returns the old value.
- A write to mhpmcounter/mhpmcounterh and an increment of the same counter at the same edge: the write wins and the increment is lost. The other half of the counter is left unchanged.
- Back-to-back event pulses count every cycle. There is no saturation.

## Configuration
- HPM_OVERFLOW_IRQ_EN defined:
  - mhpmevent[31] = sticky OF bit.
    - Set by hardware on wrap.
    - Readable and writable by CSR ops.
    - A hardware set wins over a CSR clear at the same edge.
  - mhpmevent[30] = OF interrupt enable.
  - hpm_irq = registered OR over counters of (OF & enable). It asserts one cycle after the OF bit is set.
- HPM_OVERFLOW_IRQ_EN undefined: mhpmevent[31:30] read 0, writes are ignored, and hpm_irq is tied 0.

## Test plan
- Reset, then read 0xB03, 0xB83, 0x323 and 0x320 → all 0; csr_valid=1. Read 0x7C0 → csr_valid=0.
- Write 0x323=2, then pulse events_i[1] for 5 consecutive cycles → 0xB03 reads 5 two cycles after the last pulse. 0xC03 reads 5 as well.
- Write 0xB03=0xFFFFFFFF and 0xB83=0x0, then one selected event → 0xB03=0, 0xB83=1.
- Set mcountinhibit bit 3 (0x320 op 10, 0x8), then pulse events → count is unchanged. Clear the bit → counting resumes.
- With the macro defined, CNT_WIDTH=64: write 0x323=0x40000001, set the counter to all-ones, one event → counter 0, 0x323 bit31=1, hpm_irq=1 the next cycle. Clear bit31 → hpm_irq=0 one cycle later.
- Write 0xB04=7 in the same cycle its increment edge occurs → 0xB04 reads 7, not 8. Write 0xC04 → no change.
